// File: rtl/filter_scan_ctrl.sv
// Delay-sweep sequencer for the filter bench: arms the generator, measures per-channel peaks, drains results.
// Define FILTER_SCAN_SIGNED_EN to treat ch_data/res_peak as two's-complement (signed peak compare).
module filter_scan_ctrl #(
  parameter int N_CH             = 21,
  parameter int SIZE_FILTER_DATA = 16,
  parameter int SIZE_DELAY       = 8,
  parameter int SETTLE           = 32,
  parameter int WINDOW           = 256
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             start,
  input  logic                             abort,
  input  logic                             overlay_cfg,
  input  logic [SIZE_DELAY-1:0]            delay_first,
  input  logic [SIZE_DELAY-1:0]            delay_step,
  input  logic [SIZE_DELAY-1:0]            delay_last,
  input  logic [N_CH-1:0]                  ch_mask,
  input  logic [N_CH*SIZE_FILTER_DATA-1:0] ch_data,
  output logic                             test_overlay,
  output logic                             test_rate,
  output logic [SIZE_DELAY-1:0]            test_delay,
  output logic                             res_valid,
  input  logic                             res_ready,
  output logic [4:0]                       res_channel,
  output logic [SIZE_DELAY-1:0]            res_delay,
  output logic [SIZE_FILTER_DATA-1:0]      res_peak,
  output logic                             busy,
  output logic                             done
);
  localparam int W       = SIZE_FILTER_DATA;
  localparam int CNT_MAX = (SETTLE > WINDOW) ? SETTLE : WINDOW;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {IDLE, ARM, MEASURE, DRAIN, NEXT} state_t;

  state_t                 state_reg;
  logic [SIZE_DELAY-1:0]  step_reg;
  logic [SIZE_DELAY-1:0]  last_reg;
  logic [SIZE_DELAY-1:0]  cur_delay_reg;
  logic [N_CH-1:0]        mask_reg;
  logic [N_CH-1:0]        pending_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic                   test_overlay_reg;
  logic                   test_rate_reg;
  logic                   res_valid_reg;
  logic                   busy_reg;
  logic                   done_reg;
  logic [N_CH*W-1:0]      peak_flat;

  logic [SIZE_DELAY:0]    nxt_delay;
  logic                   last_point;
  logic [N_CH-1:0]        pending_after;
  logic [4:0]             cur_ch;

  function automatic logic greater(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef FILTER_SCAN_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  function automatic logic [4:0] lowest_set(input logic [N_CH-1:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

  // The extra top bit of nxt_delay catches wrap-around of the delay register.
  assign nxt_delay     = {1'b0, cur_delay_reg} + {1'b0, step_reg};
  assign last_point    = (step_reg == '0) || nxt_delay[SIZE_DELAY] ||
                         (nxt_delay[SIZE_DELAY-1:0] > last_reg);
  assign pending_after = pending_reg & (pending_reg - {{(N_CH-1){1'b0}}, 1'b1});
  assign cur_ch        = lowest_set(pending_reg);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= IDLE;
      step_reg         <= '0;
      last_reg         <= '0;
      cur_delay_reg    <= '0;
      mask_reg         <= '0;
      pending_reg      <= '0;
      cnt_reg          <= '0;
      test_overlay_reg <= 1'b0;
      test_rate_reg    <= 1'b0;
      res_valid_reg    <= 1'b0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
    end else if (abort) begin
      state_reg        <= IDLE;
      pending_reg      <= '0;
      cnt_reg          <= '0;
      test_overlay_reg <= 1'b0;
      test_rate_reg    <= 1'b0;
      res_valid_reg    <= 1'b0;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            step_reg      <= delay_step;
            last_reg      <= delay_last;
            mask_reg      <= ch_mask;
            cur_delay_reg <= delay_first;
            cnt_reg       <= '0;
            busy_reg      <= 1'b1;
            state_reg     <= ARM;
          end
        end
        ARM: begin
          if (cnt_reg == CNT_W'(SETTLE - 1)) begin
            cnt_reg          <= '0;
            test_rate_reg    <= 1'b1;
            test_overlay_reg <= overlay_cfg;
            state_reg        <= MEASURE;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        MEASURE: begin
          test_overlay_reg <= overlay_cfg;
          if (cnt_reg == CNT_W'(WINDOW - 1)) begin
            cnt_reg          <= '0;
            test_rate_reg    <= 1'b0;
            test_overlay_reg <= 1'b0;
            if (mask_reg == '0) begin
              done_reg  <= last_point;
              state_reg <= NEXT;
            end else begin
              pending_reg   <= mask_reg;
              res_valid_reg <= 1'b1;
              state_reg     <= DRAIN;
            end
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        DRAIN: begin
          if (res_ready) begin
            pending_reg <= pending_after;
            if (pending_after == '0) begin
              res_valid_reg <= 1'b0;
              done_reg      <= last_point;
              state_reg     <= NEXT;
            end
          end
        end
        NEXT: begin
          if (last_point) begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            cur_delay_reg <= nxt_delay[SIZE_DELAY-1:0];
            state_reg     <= ARM;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Per-channel peak trackers; the first window cycle loads rather than compares.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    logic [W-1:0] ch_word;
    logic [W-1:0] peak_reg;

    assign ch_word = ch_data[gi*W +: W];
    assign peak_flat[gi*W +: W] = peak_reg;

    always_ff @(posedge clk) begin
      if (reset) begin
        peak_reg <= '0;
      end else if (state_reg == MEASURE && !abort) begin
        if (cnt_reg == '0 || greater(ch_word, peak_reg)) peak_reg <= ch_word;
      end
    end
  end

  assign test_overlay = test_overlay_reg;
  assign test_rate    = test_rate_reg;
  assign test_delay   = cur_delay_reg;
  assign res_valid    = res_valid_reg;
  assign res_channel  = res_valid_reg ? cur_ch : '0;
  assign res_delay    = res_valid_reg ? cur_delay_reg : '0;
  assign res_peak     = res_valid_reg ? peak_flat[cur_ch*W +: W] : '0;
  assign busy         = busy_reg;
  assign done         = done_reg;
endmodule

// File: tb/tb_filter_scan_ctrl.sv
// Self-checking bench for filter_scan_ctrl: randomized channel data and ready patterns against a sweep-level model.
module tb_filter_scan_ctrl;
  localparam int N_CH   = 21;
  localparam int W      = 16;
  localparam int SD     = 8;
  localparam int SETTLE = 32;
  localparam int WINDOW = 256;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              overlay_cfg = 1'b0;
  logic [SD-1:0]     delay_first = '0;
  logic [SD-1:0]     delay_step = '0;
  logic [SD-1:0]     delay_last = '0;
  logic [N_CH-1:0]   ch_mask = '0;
  logic [N_CH*W-1:0] ch_data = '0;
  logic              res_ready = 1'b0;
  logic              test_overlay, test_rate, res_valid, busy, done;
  logic [SD-1:0]     test_delay, res_delay;
  logic [4:0]        res_channel;
  logic [W-1:0]      res_peak;

  filter_scan_ctrl #(
    .N_CH(N_CH), .SIZE_FILTER_DATA(W), .SIZE_DELAY(SD), .SETTLE(SETTLE), .WINDOW(WINDOW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .overlay_cfg(overlay_cfg),
    .delay_first(delay_first), .delay_step(delay_step), .delay_last(delay_last),
    .ch_mask(ch_mask), .ch_data(ch_data),
    .test_overlay(test_overlay), .test_rate(test_rate), .test_delay(test_delay),
    .res_valid(res_valid), .res_ready(res_ready), .res_channel(res_channel),
    .res_delay(res_delay), .res_peak(res_peak), .busy(busy), .done(done)
  );

  int total = 0;
  int bad = 0;
  bit broken;

  typedef struct {int ch; int d; int pk;} res_t;
  res_t exp_q[$];
  int   pk[N_CH];

  function automatic int pk_max(int a, int b);
    logic [W-1:0] ua, ub;
    ua = a[W-1:0];
    ub = b[W-1:0];
`ifdef FILTER_SCAN_SIGNED_EN
    return ($signed(ua) > $signed(ub)) ? a : b;
`else
    return (ua > ub) ? a : b;
`endif
  endfunction

  // One sweep point, entered just before the first ARM-cycle negedge.
  task automatic run_point(input int d, input logic [N_CH-1:0] mask, input int rmode,
                           input int dmode, input bit swb, input bit lastp);
    bit           ok, hold, r;
    string        msg;
    int           nres, cyc, v;
    res_t         e;
    logic [4:0]   h_ch;
    logic [SD-1:0] h_d;
    logic [W-1:0] h_pk;

    ok = 1;
    for (int c = 0; c < SETTLE; c++) begin
      @(negedge clk);
      start = (swb && c == 2);
      if (swb && c == 2) delay_first = delay_first + 8'd7;
      if (ok && (test_delay !== SD'(d) || test_rate !== 1'b0 || test_overlay !== 1'b0 ||
                 busy !== 1'b1 || done !== 1'b0 || res_valid !== 1'b0)) begin
        ok = 0;
        msg = $sformatf("cycle %0d delay=%0d rate=%b ovl=%b busy=%b done=%b valid=%b", c,
                        test_delay, test_rate, test_overlay, busy, done, res_valid);
      end
    end
    start = 1'b0;
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL arm d=%0d: got %s, want delay=%0d rate=0 ovl=0 busy=1 done=0 valid=0", d, msg, d);
    end

    ok = 1;
    for (int c = 0; c < WINDOW; c++) begin
      @(negedge clk);
      if (ok && (test_rate !== 1'b1 || test_overlay !== overlay_cfg || test_delay !== SD'(d) ||
                 busy !== 1'b1 || res_valid !== 1'b0)) begin
        ok = 0;
        msg = $sformatf("cycle %0d rate=%b ovl=%b delay=%0d busy=%b valid=%b", c,
                        test_rate, test_overlay, test_delay, busy, res_valid);
      end
      for (int i = 0; i < N_CH; i++) begin
        v = int'($urandom_range(0, 65535) >> (i % 12));
        if (dmode == 1 && i == 3) v = c;
        if (dmode == 2 && i == 0) v = 'hFFFB;
        if (dmode == 3 && i == 0) v = (c == 0) ? 1 : 'hFFFB;
        ch_data[i*W +: W] = v[W-1:0];
        pk[i] = (c == 0) ? v : pk_max(pk[i], v);
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL measure d=%0d: got %s, want rate=1 ovl=%b delay=%0d busy=1 valid=0",
               d, msg, overlay_cfg, d);
    end

    for (int i = 0; i < N_CH; i++) if (mask[i]) exp_q.push_back('{i, d, pk[i]});
    nres = exp_q.size();

    cyc = 0;
    hold = 0;
    while (exp_q.size() > 0 && cyc < 40 * N_CH) begin
      @(negedge clk);
      cyc++;
      if (hold) begin
        total++;
        if (res_valid !== 1'b1 || res_channel !== h_ch || res_delay !== h_d || res_peak !== h_pk) begin
          bad++;
          $display("FAIL hold: got valid=%b ch=%0d d=%0d peak=%h, want valid=1 ch=%0d d=%0d peak=%h",
                   res_valid, res_channel, res_delay, res_peak, h_ch, h_d, h_pk);
        end
      end
      case (rmode)
        0:       r = 1'b1;
        1:       r = (cyc % 2 == 0);
        2:       r = (cyc > 7);
        default: r = 1'($urandom % 2);
      endcase
      res_ready = r;
      if (res_valid === 1'b1 && r) begin
        e = exp_q.pop_front();
        total++;
        if (res_channel !== 5'(e.ch) || res_delay !== SD'(e.d) || res_peak !== W'(e.pk)) begin
          bad++;
          $display("FAIL result: got ch=%0d d=%0d peak=%h, want ch=%0d d=%0d peak=%h",
                   res_channel, res_delay, res_peak, e.ch, e.d, W'(e.pk));
        end else begin
          $display("result ch=%0d delay=%0d peak=%h", res_channel, res_delay, res_peak);
        end
      end
      hold = (res_valid === 1'b1 && !r);
      h_ch = res_channel;
      h_d  = res_delay;
      h_pk = res_peak;
    end
    total++;
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain timeout d=%0d: got %0d results left, want 0", d, exp_q.size());
      exp_q.delete();
      broken = 1;
      return;
    end
    if (rmode == 0) begin
      total++;
      if (cyc != nres) begin
        bad++;
        $display("FAIL throughput d=%0d: got %0d cycles, want %0d", d, cyc, nres);
      end
    end

    @(negedge clk);
    res_ready = 1'b0;
    total++;
    if (res_valid !== 1'b0 || busy !== 1'b1 || done !== lastp || test_rate !== 1'b0) begin
      bad++;
      $display("FAIL next d=%0d: got valid=%b busy=%b done=%b rate=%b, want valid=0 busy=1 done=%b rate=0",
               d, res_valid, busy, done, test_rate, lastp);
    end
    if (lastp) begin
      @(negedge clk);
      total++;
      if (busy !== 1'b0 || done !== 1'b0 || res_valid !== 1'b0) begin
        bad++;
        $display("FAIL idle: got busy=%b done=%b valid=%b, want 0 0 0", busy, done, res_valid);
      end
    end
  endtask

  task automatic run_sweep(input string name, input int first, input int step, input int last,
                           input logic [N_CH-1:0] mask, input int rmode, input int dmode, input bit swb);
    int d, nxt, npts;
    bit lastp, sw;
    @(negedge clk);
    delay_first = SD'(first);
    delay_step  = SD'(step);
    delay_last  = SD'(last);
    ch_mask     = mask;
    overlay_cfg = 1'($urandom % 2);
    res_ready   = 1'b0;
    start       = 1'b1;
    d = first;
    npts = 0;
    broken = 0;
    sw = swb;
    forever begin
      nxt   = d + step;
      lastp = (step == 0) || (nxt > 255) || (nxt > last);
      run_point(d, mask, rmode, dmode, sw, lastp);
      npts++;
      if (broken || lastp) break;
      d = nxt;
      sw = 0;
    end
    if (broken) begin
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
    end
    $display("sweep %s first=%0d step=%0d last=%0d mask=%h points=%0d", name, first, step, last, mask, npts);
  endtask

  task automatic check_idle(input string name);
    total++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || done !== 1'b0 || test_rate !== 1'b0 || test_overlay !== 1'b0) begin
      bad++;
      $display("FAIL %s: got busy=%b valid=%b done=%b rate=%b ovl=%b, want all 0",
               name, busy, res_valid, done, test_rate, test_overlay);
    end else begin
      $display("idle check %s ok", name);
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_idle("reset_ctrl");
    total++;
    if (test_delay !== '0 || res_channel !== '0 || res_delay !== '0 || res_peak !== '0) begin
      bad++;
      $display("FAIL reset_data: got delay=%0d ch=%0d rd=%0d peak=%h, want all 0",
               test_delay, res_channel, res_delay, res_peak);
    end
  endtask

  task automatic test_basic_sweep;
    run_sweep("basic", 10, 5, 20, 21'b101, 0, 0, 0);
  endtask

  task automatic test_ramp_and_overflow;
    run_sweep("ramp", 77, 3, 50, 21'(1 << 3), 0, 1, 0);
    run_sweep("overflow", 250, 10, 255, 21'h100001, 0, 0, 0);
  endtask

  task automatic test_backpressure;
    run_sweep("ready_gap", 40, 20, 60, 21'h0F0F1, 2, 0, 0);
    run_sweep("ready_toggle", 0, 100, 200, 21'h1FFFFF, 1, 0, 0);
  endtask

  task automatic test_abort;
    @(negedge clk);
    delay_first = 8'd30; delay_step = 8'd1; delay_last = 8'd40; ch_mask = 21'h7;
    res_ready = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (SETTLE + 9) @(negedge clk);
    total++;
    if (test_rate !== 1'b1) begin
      bad++;
      $display("FAIL abort_pre_measure: got rate=%b, want 1", test_rate);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_idle("abort_measure");
    repeat (5) @(negedge clk);
    check_idle("abort_measure_stay");

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (SETTLE + WINDOW + 2) @(negedge clk);
    total++;
    if (res_valid !== 1'b1 || busy !== 1'b1) begin
      bad++;
      $display("FAIL abort_pre_drain: got valid=%b busy=%b, want 1 1", res_valid, busy);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_idle("abort_drain");

    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check_idle("start_with_abort");

    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (SETTLE + 20) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle("reset_mid_sweep");
    total++;
    if (test_delay !== '0 || res_peak !== '0) begin
      bad++;
      $display("FAIL reset_mid_data: got delay=%0d peak=%h, want 0 0", test_delay, res_peak);
    end

    run_sweep("after_abort", 30, 5, 35, 21'h00C03, 0, 0, 0);
  endtask

  task automatic test_sign;
    run_sweep("neg_const", 5, 0, 5, 21'h1, 0, 2, 0);
    run_sweep("pos_then_neg", 6, 0, 6, 21'h1, 0, 3, 0);
  endtask

  task automatic test_mask_zero;
    run_sweep("mask_zero_start_busy", 123, 0, 0, '0, 0, 0, 1);
  endtask

  task automatic test_random;
    for (int k = 0; k < 4; k++) begin
      int f, s, l;
      f = int'($urandom_range(0, 255));
      s = int'($urandom_range(1, 90));
      l = f + s * int'($urandom_range(0, 2)) + int'($urandom_range(0, s - 1));
      if (l > 255) l = 255;
      run_sweep("random", f, s, l, N_CH'($urandom), 3, 0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_basic_sweep();
    test_ramp_and_overflow();
    test_backpressure();
    test_abort();
    test_sign();
    test_mask_zero();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got time limit reached, want completion (total=%0d bad=%0d)", total, bad);
    $fatal(1, "watchdog expired");
  end
endmodule
